// File: rtl/nes_pkg.sv
// Shared constants for the NES joypad port: button bit positions, USB HID
// keycodes bound to each button, and the CPU addresses of the two pad ports.
package nes_pkg;

   typedef enum logic [2:0] {
      NES_BTN_A      = 3'd0,
      NES_BTN_B      = 3'd1,
      NES_BTN_SELECT = 3'd2,
      NES_BTN_START  = 3'd3,
      NES_BTN_UP     = 3'd4,
      NES_BTN_DOWN   = 3'd5,
      NES_BTN_LEFT   = 3'd6,
      NES_BTN_RIGHT  = 3'd7
   } nes_btn_e;

   localparam logic [7:0] KC_NONE  = 8'h00;
   localparam logic [7:0] KC_Z     = 8'h1D;
   localparam logic [7:0] KC_X     = 8'h1B;
   localparam logic [7:0] KC_TAB   = 8'h2B;
   localparam logic [7:0] KC_ENTER = 8'h28;
   localparam logic [7:0] KC_UP    = 8'h52;
   localparam logic [7:0] KC_DOWN  = 8'h51;
   localparam logic [7:0] KC_LEFT  = 8'h50;
   localparam logic [7:0] KC_RIGHT = 8'h4F;

   localparam logic [15:0] JOY1_ADDR = 16'h4016;
   localparam logic [15:0] JOY2_ADDR = 16'h4017;

   // One-hot button vector for a held keycode; anything unmapped reads as no buttons.
   function automatic logic [7:0] map_keycode(input logic [7:0] kc);
      logic [7:0] btn;
      btn = 8'h00;
      case (kc)
         KC_Z:     btn[NES_BTN_A]      = 1'b1;
         KC_X:     btn[NES_BTN_B]      = 1'b1;
         KC_TAB:   btn[NES_BTN_SELECT] = 1'b1;
         KC_ENTER: btn[NES_BTN_START]  = 1'b1;
         KC_UP:    btn[NES_BTN_UP]     = 1'b1;
         KC_DOWN:  btn[NES_BTN_DOWN]   = 1'b1;
         KC_LEFT:  btn[NES_BTN_LEFT]   = 1'b1;
         KC_RIGHT: btn[NES_BTN_RIGHT]  = 1'b1;
         default:  btn = 8'h00;
      endcase
      return btn;
   endfunction

endpackage

// File: rtl/nes_joypad_port_filter.sv
// Keycode stability filter: a raw keycode from the SoC domain is only passed on
// once it has held the same value for STABLE_CYCLES consecutive clocks.
module keycode_stable_filter
   import nes_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] keycode,
   output logic [7:0] held
);

   localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [7:0]    sample;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          commit;

   // Any difference against the last sample restarts the count, so multi-bit
   // skew while the keycode settles never reaches the held value.
   always_comb begin
      count_nxt = count;
      commit    = 1'b0;
      if (keycode != sample) begin
         count_nxt = '0;
      end else begin
         if (count != CNT_MAX) begin
            count_nxt = count + 1'b1;
         end
         commit = (count_nxt == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample <= KC_NONE;
         count  <= '0;
         held   <= KC_NONE;
      end else begin
         sample <= keycode;
         count  <= count_nxt;
         if (commit) begin
            held <= sample;
         end
      end
   end

endmodule

// File: rtl/nes_joypad_port.sv
// NES controller port ($4016/$4017): filters the USB keycode, maps it to pad
// buttons and serves them to the CPU via the strobe/serial-shift protocol.
module nes_joypad_port
   import nes_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter logic [7:0]  OPEN_BUS      = 8'h40
) (
   input  logic        CPU_CLK,
   input  logic        Reset_h,
   input  logic [7:0]  keycode,
   input  logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw_n,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dout_vld,
   output logic [7:0]  buttons_dbg
);

   logic [7:0] held_kc;
   logic [7:0] buttons;
   logic       strobe;
   logic [7:0] shift_reg;
   logic       wr_joy1;
   logic       rd_joy1;
   logic       rd_joy2;
   logic       rd_bit;
   logic       unused_din;

   keycode_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk     (CPU_CLK),
      .rst     (Reset_h),
      .keycode (keycode),
      .held    (held_kc)
   );

   assign buttons     = map_keycode(held_kc);
   assign buttons_dbg = buttons;

   // Only bit 0 of a $4016 write matters; the rest belongs to the expansion port.
   assign unused_din = ^cpu_din[7:1];

   // Bus qualifiers are only trusted on the cpu_ce pulse, so a read that
   // holds the bus for several clocks is seen exactly once.
   always_comb begin
      wr_joy1 = 1'b0;
      rd_joy1 = 1'b0;
      rd_joy2 = 1'b0;
      if (cpu_ce) begin
         wr_joy1 = !cpu_rw_n && (cpu_addr == JOY1_ADDR);
         rd_joy1 =  cpu_rw_n && (cpu_addr == JOY1_ADDR);
         rd_joy2 =  cpu_rw_n && (cpu_addr == JOY2_ADDR);
      end
   end

   // While strobed the pad reports live A; otherwise the latched serial bit.
   assign rd_bit = strobe ? buttons[NES_BTN_A] : shift_reg[0];

   always_ff @(posedge CPU_CLK) begin
      if (Reset_h) begin
         strobe       <= 1'b0;
         shift_reg    <= 8'h00;
         cpu_dout     <= OPEN_BUS;
         cpu_dout_vld <= 1'b0;
      end else begin
         cpu_dout_vld <= rd_joy1 || rd_joy2;

         if (wr_joy1) begin
            strobe <= cpu_din[0];
         end

         // The falling-strobe write clock still sees strobe=1, which is what
         // captures the final latch; afterwards only reads move the register.
         if (strobe) begin
            shift_reg <= buttons;
         end else if (rd_joy1) begin
            shift_reg <= {1'b1, shift_reg[7:1]};
         end

         if (rd_joy1) begin
            cpu_dout <= {OPEN_BUS[7:1], rd_bit};
         end else if (rd_joy2) begin
            cpu_dout <= {OPEN_BUS[7:1], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port: reads push expected data into a queue,
// a negedge monitor pops and compares whenever cpu_dout_vld is high.
module tb_nes_joypad_port;

   logic        clk;
   logic        rst;
   logic [7:0]  keycode;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic        cpu_rw_n;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_dout_vld;
   logic [7:0]  buttons_dbg;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   nes_joypad_port #(
      .STABLE_CYCLES (16),
      .OPEN_BUS      (8'h40)
   ) dut (
      .CPU_CLK      (clk),
      .Reset_h      (rst),
      .keycode      (keycode),
      .cpu_ce       (cpu_ce),
      .cpu_addr     (cpu_addr),
      .cpu_rw_n     (cpu_rw_n),
      .cpu_din      (cpu_din),
      .cpu_dout     (cpu_dout),
      .cpu_dout_vld (cpu_dout_vld),
      .buttons_dbg  (buttons_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cpu_dout_vld !== 1'b0) begin
         if (exp_q.size() == 0) check("unexpected_vld", 32'(cpu_dout_vld), 32'd0);
         else check("rd_data", 32'(cpu_dout), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cpu_ce = 1'b1; cpu_rw_n = 1'b0; cpu_addr = a; cpu_din = d;
      @(posedge clk); #1;
      cpu_ce = 1'b0; cpu_rw_n = 1'b1;
   endtask

   // Address and rw_n stay asserted after ce drops, like a multi-clock bus read.
   task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
      @(posedge clk); #1;
      cpu_ce = 1'b1; cpu_rw_n = 1'b1; cpu_addr = a;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      cpu_ce = 1'b0;
      wait_clks(2);
   endtask

   task automatic latch;
      bus_write(16'h4016, 8'h01);
      bus_write(16'h4016, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; keycode = 8'h00; cpu_ce = 1'b0; cpu_addr = 16'h0000;
      cpu_rw_n = 1'b1; cpu_din = 8'h00;
      wait_clks(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_dout", 32'(cpu_dout), 32'h40);
      check("rst_vld", 32'(cpu_dout_vld), 32'd0);
      check("rst_buttons", 32'(buttons_dbg), 32'h00);

      // 1: A held, full read sequence and trailing ones
      keycode = 8'h1D;
      wait_clks(20);
      @(negedge clk);
      check("t1_buttons", 32'(buttons_dbg), 32'h01);
      latch();
      bus_read(16'h4016, 8'h41);
      for (int i = 0; i < 7; i++) bus_read(16'h4016, 8'h40);
      bus_read(16'h4016, 8'h41);
      bus_read(16'h4016, 8'h41);

      // 2: bouncing keycode never commits; a steady one commits after 16 clocks
      keycode = 8'h00;
      wait_clks(20);
      for (int i = 0; i < 6; i++) begin
         keycode = (i % 2 == 0) ? 8'h52 : 8'h00;
         for (int j = 0; j < 5; j++) begin
            @(posedge clk); @(negedge clk);
            check("t2_bounce", 32'(buttons_dbg), 32'h00);
         end
      end
      keycode = 8'h52;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); @(negedge clk);
         check("t2_commit", 32'(buttons_dbg), (k < 16) ? 32'h00 : 32'h10);
      end

      // 3: strobe held high reports live A without shifting
      keycode = 8'h28;
      wait_clks(20);
      bus_write(16'h4016, 8'h01);
      for (int i = 0; i < 3; i++) bus_read(16'h4016, 8'h40);
      keycode = 8'h1D;
      wait_clks(20);
      bus_read(16'h4016, 8'h41);
      bus_write(16'h4016, 8'h00);

      // 4: keycode change mid-shift leaves the latched Right sequence intact
      keycode = 8'h4F;
      wait_clks(20);
      latch();
      keycode = 8'h1D;
      for (int i = 0; i < 7; i++) bus_read(16'h4016, 8'h40);
      bus_read(16'h4016, 8'h41);

      // 5: pad 2 reads, $4017 writes ignored, foreign address leaves dout alone
      wait_clks(20);
      latch();
      bus_read(16'h4016, 8'h41);
      bus_read(16'h4017, 8'h40);
      bus_write(16'h4017, 8'h01);
      bus_read(16'h4016, 8'h40);
      @(posedge clk); #1;
      cpu_ce = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 16'h5000;
      @(posedge clk); @(negedge clk);
      cpu_ce = 1'b0;
      check("t5_other_vld", 32'(cpu_dout_vld), 32'd0);
      check("t5_other_dout", 32'(cpu_dout), 32'h40);

      // 6: reset mid-shift, then a fresh full sequence
      latch();
      bus_read(16'h4016, 8'h41);
      bus_read(16'h4016, 8'h40);
      bus_read(16'h4016, 8'h40);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_dout", 32'(cpu_dout), 32'h40);
      check("t6_rst_vld", 32'(cpu_dout_vld), 32'd0);
      check("t6_rst_buttons", 32'(buttons_dbg), 32'h00);
      wait_clks(20);
      @(negedge clk);
      check("t6_buttons", 32'(buttons_dbg), 32'h01);
      latch();
      bus_read(16'h4016, 8'h41);
      for (int i = 0; i < 7; i++) bus_read(16'h4016, 8'h40);

      wait_clks(5);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
